// File: rtl/sand_sweep_ctrl.sv
// Sweep/clear sequencer for the double-buffered sandpile tile RAM.
// Optional macro SAND_SWEEP_LIMIT_EN stops a run after MAX_SWEEPS changing passes.
module sand_sweep_ctrl #(
    parameter int ROWS       = 128,
    parameter int COLS       = 128,
    parameter int ROWS_TILE  = 4,
    parameter int COLS_TILE  = 4,
    parameter int NUM_TILES  = (ROWS / ROWS_TILE) * (COLS / COLS_TILE),
    parameter int MAX_SWEEPS = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear_req,
    input  logic        abort,
    input  logic        comp_done,
    input  logic        tile_changed,
    output logic        comp_start,
    output logic [9:0]  tile_addr,
    output logic        read_tile,
    output logic        write_tile,
    output logic        reset_tile,
    output logic        read_ram_a,
    output logic        busy,
    output logic        done,
    output logic        stable,
    output logic [15:0] sweep_count
);

`ifdef SAND_SWEEP_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam logic [9:0]  LAST_TILE = 10'(NUM_TILES - 1);
    localparam logic [15:0] SWEEP_MAX = 16'(MAX_SWEEPS);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_READ, S_LATCH, S_COMPUTE, S_WRITE, S_SWEEP_END
    } state_t;

    state_t      state_q;
    logic [9:0]  addr_q;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        changed_q;
    logic        clr_pass_q;
    logic        limit_hit_d;
    logic        comp_start_q, read_q, write_q, reset_q;
    logic        rama_q, busy_q, done_q, stable_q;

    // Saturating pass count and the sweep-budget stop condition.
    always_comb begin
        count_d     = count_q;
        limit_hit_d = 1'b0;
        if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
        if (LIMIT_EN && (count_d == SWEEP_MAX) && changed_q) begin
            limit_hit_d = 1'b1;
        end else begin
            limit_hit_d = 1'b0;
        end
    end

    // Controller FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= 10'd0;
            count_q      <= 16'd0;
            changed_q    <= 1'b0;
            clr_pass_q   <= 1'b0;
            comp_start_q <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            reset_q      <= 1'b0;
            rama_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stable_q     <= 1'b0;
        end else begin
            comp_start_q <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            reset_q      <= 1'b0;
            done_q       <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                addr_q  <= 10'd0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (clear_req) begin
                            state_q    <= S_CLR;
                            addr_q     <= 10'd0;
                            clr_pass_q <= 1'b0;
                            busy_q     <= 1'b1;
                            reset_q    <= 1'b1;
                        end else if (start) begin
                            state_q   <= S_READ;
                            addr_q    <= 10'd0;
                            count_q   <= 16'd0;
                            stable_q  <= 1'b0;
                            changed_q <= 1'b0;
                            busy_q    <= 1'b1;
                            read_q    <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_CLR: begin
                        if (addr_q == LAST_TILE) begin
                            // Flip banks so the second pass clears the other one.
                            rama_q <= ~rama_q;
                            addr_q <= 10'd0;
                            if (clr_pass_q) begin
                                state_q  <= S_IDLE;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                stable_q <= 1'b0;
                            end else begin
                                clr_pass_q <= 1'b1;
                                reset_q    <= 1'b1;
                            end
                        end else begin
                            addr_q  <= addr_q + 10'd1;
                            reset_q <= 1'b1;
                        end
                    end
                    S_READ: begin
                        // Keep the read strobe up so the RAM output mux stays open.
                        state_q      <= S_LATCH;
                        read_q       <= 1'b1;
                        comp_start_q <= 1'b1;
                    end
                    S_LATCH: begin
                        state_q <= S_COMPUTE;
                    end
                    S_COMPUTE: begin
                        if (comp_done) begin
                            changed_q <= changed_q | tile_changed;
                            state_q   <= S_WRITE;
                            write_q   <= 1'b1;
                        end else begin
                            state_q <= S_COMPUTE;
                        end
                    end
                    S_WRITE: begin
                        if (addr_q == LAST_TILE) begin
                            state_q <= S_SWEEP_END;
                        end else begin
                            addr_q  <= addr_q + 10'd1;
                            state_q <= S_READ;
                            read_q  <= 1'b1;
                        end
                    end
                    S_SWEEP_END: begin
                        count_q <= count_d;
                        if (limit_hit_d) begin
                            rama_q   <= ~rama_q;
                            stable_q <= 1'b0;
                            addr_q   <= 10'd0;
                            state_q  <= S_IDLE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else if (changed_q) begin
                            rama_q    <= ~rama_q;
                            changed_q <= 1'b0;
                            addr_q    <= 10'd0;
                            state_q   <= S_READ;
                            read_q    <= 1'b1;
                        end else begin
                            stable_q <= 1'b1;
                            addr_q   <= 10'd0;
                            state_q  <= S_IDLE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        addr_q  <= 10'd0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign comp_start  = comp_start_q;
    assign tile_addr   = addr_q;
    assign read_tile   = read_q;
    assign write_tile  = write_q;
    assign reset_tile  = reset_q;
    assign read_ram_a  = rama_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign stable      = stable_q;
    assign sweep_count = count_q;

endmodule

// File: tb/tb_sand_sweep_ctrl.sv
// Self-checking bench for sand_sweep_ctrl on an 8x8 grid of 4x4 tiles (4 tiles per pass).
module tb_sand_sweep_ctrl;

    localparam int          N    = 4;
    localparam logic [15:0] MAXS = 16'd3;
`ifdef SAND_SWEEP_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    typedef struct packed {
        logic start, clear_req, abort, comp_done, tile_changed;
    } in_t;

    typedef struct packed {
        logic        cs;
        logic [9:0]  addr;
        logic        rd, wr, rs, rama, busy, done, stable;
        logic [15:0] cnt;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clear_req, abort, comp_done, tile_changed;
    logic        comp_start, read_tile, write_tile, reset_tile, read_ram_a, busy, done, stable;
    logic [9:0]  tile_addr;
    logic [15:0] sweep_count;

    int   vectors = 0;
    int   miscompares = 0;
    vec_t vq[$];

    // Reference model state: what the spec says the persistent outputs hold.
    logic        m_rama   = 1'b1;
    logic        m_stable = 1'b0;
    logic [15:0] m_count  = 16'd0;

    sand_sweep_ctrl #(
        .ROWS(8), .COLS(8), .ROWS_TILE(4), .COLS_TILE(4), .MAX_SWEEPS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear_req(clear_req), .abort(abort),
        .comp_done(comp_done), .tile_changed(tile_changed), .comp_start(comp_start),
        .tile_addr(tile_addr), .read_tile(read_tile), .write_tile(write_tile),
        .reset_tile(reset_tile), .read_ram_a(read_ram_a), .busy(busy), .done(done),
        .stable(stable), .sweep_count(sweep_count)
    );

    always #5 clk = ~clk;

    function automatic out_t idle_o(logic d);
        out_t o;
        o = '0;
        o.rama = m_rama; o.done = d; o.stable = m_stable; o.cnt = m_count;
        return o;
    endfunction

    function automatic out_t busy_o(int a, logic rd, logic wr, logic rs, logic cs);
        out_t o;
        o = '0;
        o.addr = 10'(a); o.rd = rd; o.wr = wr; o.rs = rs; o.cs = cs;
        o.rama = m_rama; o.busy = 1'b1; o.stable = m_stable; o.cnt = m_count;
        return o;
    endfunction

    // Noise on inputs the controller must ignore in the current cycle.
    function automatic in_t junk(bit allow_cd);
        in_t r;
        r = '0;
        r.start        = ($urandom_range(0, 3) == 0);
        r.clear_req    = ($urandom_range(0, 3) == 0);
        r.tile_changed = 1'($urandom_range(0, 1));
        r.comp_done    = allow_cd && ($urandom_range(0, 1) == 1);
        return r;
    endfunction

    function automatic bit pick(int mode, int pass, int t);
        case (mode)
            0:       return 1'b0;
            1:       return (pass == 0) && (t == 2);
            2:       return 1'b1;
            default: return (pass < 3) && ($urandom_range(0, 2) == 0);
        endcase
    endfunction

    task automatic push(in_t i, out_t o);
        vec_t v;
        v.i = i; v.o = o;
        vq.push_back(v);
    endtask

    task automatic add_idle(int n);
        in_t i;
        for (int c = 0; c < n; c++) begin
            i = junk(1'b1); i.start = 1'b0; i.clear_req = 1'b0;
            push(i, idle_o(1'b0));
        end
    endtask

    task automatic add_clear();
        in_t i;
        i = '0; i.clear_req = 1'b1; i.start = 1'($urandom_range(0, 1));
        push(i, idle_o(1'b0));
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < N; a++) push(junk(1'b1), busy_o(a, 1'b0, 1'b0, 1'b1, 1'b0));
            m_rama = ~m_rama;
        end
        m_stable = 1'b0;
        push('0, idle_o(1'b1));
    endtask

    // Expands one run into per-cycle vectors: 3+k cycles per tile, one end-of-pass cycle.
    task automatic add_sweep(int mode, int abort_pass, int abort_tile, int kmax);
        in_t i;
        bit  chg, c, fin;
        int  k, pass;
        i = '0; i.start = 1'b1;
        push(i, idle_o(1'b0));
        m_count = 16'd0; m_stable = 1'b0; pass = 0; fin = 1'b0;
        while (!fin) begin
            chg = 1'b0;
            for (int t = 0; t < N; t++) begin
                c = pick(mode, pass, t);
                k = $urandom_range(1, kmax);
                push(junk(1'b1), busy_o(t, 1'b1, 1'b0, 1'b0, 1'b0));
                push(junk(1'b1), busy_o(t, 1'b1, 1'b0, 1'b0, 1'b1));
                if (pass == abort_pass && t == abort_tile) begin
                    i = '0; i.abort = 1'b1;
                    push(i, busy_o(t, 1'b0, 1'b0, 1'b0, 1'b0));
                    push('0, idle_o(1'b1));
                    return;
                end
                for (int j = 1; j <= k; j++) begin
                    i = junk(1'b0);
                    if (j == k) begin i.comp_done = 1'b1; i.tile_changed = c; end
                    push(i, busy_o(t, 1'b0, 1'b0, 1'b0, 1'b0));
                end
                push(junk(1'b1), busy_o(t, 1'b0, 1'b1, 1'b0, 1'b0));
                chg |= c;
            end
            push(junk(1'b1), busy_o(N - 1, 1'b0, 1'b0, 1'b0, 1'b0));
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (LIM && m_count == MAXS && chg) begin m_rama = ~m_rama; fin = 1'b1; end
            else if (chg) m_rama = ~m_rama;
            else begin m_stable = 1'b1; fin = 1'b1; end
            pass++;
        end
        push('0, idle_o(1'b1));
    endtask

    task automatic check(out_t e, string tag, int n);
        out_t a;
        a.cs = comp_start; a.addr = tile_addr; a.rd = read_tile; a.wr = write_tile;
        a.rs = reset_tile; a.rama = read_ram_a; a.busy = busy; a.done = done;
        a.stable = stable; a.cnt = sweep_count;
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s #%0d: got cs=%b addr=%0d rd=%b wr=%b rs=%b rama=%b busy=%b done=%b stable=%b cnt=%0d, want cs=%b addr=%0d rd=%b wr=%b rs=%b rama=%b busy=%b done=%b stable=%b cnt=%0d",
                     tag, n, a.cs, a.addr, a.rd, a.wr, a.rs, a.rama, a.busy, a.done, a.stable, a.cnt,
                     e.cs, e.addr, e.rd, e.wr, e.rs, e.rama, e.busy, e.done, e.stable, e.cnt);
        end
    endtask

    task automatic drive(in_t i);
        start = i.start; clear_req = i.clear_req; abort = i.abort;
        comp_done = i.comp_done; tile_changed = i.tile_changed;
    endtask

    task automatic apply(string tag);
        for (int n = 0; n < vq.size(); n++) begin
            @(posedge clk); #1;
            check(vq[n].o, tag, n);
            drive(vq[n].i);
        end
        vq.delete();
        drive('0);
    endtask

    task automatic reset_model();
        m_rama = 1'b1; m_stable = 1'b0; m_count = 16'd0;
    endtask

    initial begin
        drive('0);
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 check(idle_o(1'b0), "reset", 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Directed scenarios: idle, clear, quiet run, one changing tile.
        add_idle(2);
        add_clear();
        add_idle(1);
        add_sweep(0, -1, 0, 1);
        add_idle(1);
        add_sweep(1, -1, 0, 1);
        add_idle(1);
        apply("directed");

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        reset_model();
        #1 check(idle_o(1'b0), "async_rst", 0);
        @(negedge clk) rst_n = 1'b1;

        // Abort mid-compute, restart, then a run that changes every pass.
        add_idle(1);
        add_sweep(0, 0, 1, 2);
        add_idle(1);
        add_sweep(0, -1, 0, 3);
        add_idle(1);
        add_sweep(2, 4, 0, 1);
        add_idle(1);
        apply("corner");

        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 3) == 0) add_clear();
            else if ($urandom_range(0, 2) == 0)
                add_sweep(3, $urandom_range(0, 2), $urandom_range(0, N - 1), 4);
            else add_sweep(3, -1, 0, 4);
            add_idle($urandom_range(0, 2));
        end
        add_idle(1);
        apply("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sand_sweep_ctrl.md
# sand_sweep_ctrl

Sequencing controller for the double-buffered sandpile tile RAM. On request it sweeps every tile once per pass: read from the source bank, hand the tile to the external topple compute unit, write the result to the destination bank. It swaps banks between passes and stops when a full pass changes nothing. It also clears both banks on command and drives the RAM block's `tile_addr`, `read_tile`, `write_tile`, `reset_tile` and `read_ram_a` controls.

## Interface
Parameters:
- `ROWS`, default 128: grid rows; must be a multiple of `ROWS_TILE`.
- `COLS`, default 128: grid columns; must be a multiple of `COLS_TILE`.
- `ROWS_TILE`, default 4: tile height.
- `COLS_TILE`, default 4: tile width.
- `NUM_TILES`, default `(ROWS/ROWS_TILE)*(COLS/COLS_TILE)`: tiles per sweep, 1..1024.
- `MAX_SWEEPS`, default 1000: sweep budget; used only with `SAND_SWEEP_LIMIT_EN`.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: pulse; begin sweeping. Only honoured in IDLE.
- `clear_req`, in, 1: pulse; zero both banks. Only honoured in IDLE.
- `abort`, in, 1: return to IDLE next cycle from any state.
- `comp_done`, in, 1: compute unit finished the current tile.
- `tile_changed`, in, 1: qualified by `comp_done`; the tile differs from its input.
- `comp_start`, out, 1: one-cycle pulse; `tile_data_o` is valid this cycle.
- `tile_addr`, out, 10: tile address to the RAM.
- `read_tile`, out, 1: RAM source-bank read.
- `write_tile`, out, 1: RAM destination-bank write.
- `reset_tile`, out, 1: RAM destination-bank clear.
- `read_ram_a`, out, 1: 1 means bank A is the source and bank B the destination.
- `busy`, out, 1: high whenever the controller is not in IDLE.
- `done`, out, 1: one-cycle pulse on return to IDLE after a sweep run or clear, including abort.
- `stable`, out, 1: the last run ended on a pass with no tile changes.
- `sweep_count`, out, 16: completed passes in the current run; saturates at 0xFFFF.

## Operation
- All outputs are registered. Reset values: `read_ram_a`=1, `stable`=0, all other outputs 0. State resets to IDLE.
- States are IDLE, CLR, READ, LATCH, COMPUTE, WRITE, SWEEP_END.
- IDLE:
  - `clear_req` goes to CLR. It wins over a simultaneous `start`.
  - `start` goes to READ with `tile_addr`=0, `sweep_count`=0, `stable`=0 and the changed-flag cleared.
- CLR:
  - Two passes of `NUM_TILES` cycles, `reset_tile`=1 with `tile_addr` = 0..N-1, one tile per cycle.
  - `read_ram_a` toggles after each pass, so it ends at its entry value and both banks are cleared.
  - Then `stable` is cleared, `done` pulses and the FSM returns to IDLE.
- READ: `read_tile`=1 for one cycle, then LATCH.
- LATCH: `read_tile` stays 1 so the RAM output mux stays open. `comp_start`=1. Then COMPUTE.
- COMPUTE:
  - Waits for `comp_done` with no timeout.
  - On `comp_done`, OR `tile_changed` into the changed-flag and go to WRITE.
- WRITE: `write_tile`=1 for one cycle at the same `tile_addr`.
  - If `tile_addr`=N-1, go to SWEEP_END.
  - Otherwise increment `tile_addr` and go to READ.
- SWEEP_END:
  - Increment `sweep_count` (saturating).
  - If the changed-flag is set: toggle `read_ram_a`, clear the flag, set `tile_addr`=0 and go to READ.
  - If the flag is clear: set `stable`=1, pulse `done`, go to IDLE. `read_ram_a` is unchanged because both banks hold identical data.
- `abort`:
  - Next cycle: state IDLE, all strobes 0, `done` pulses.
  - `read_ram_a`, `sweep_count` and `stable` hold. A write that was not yet issued is lost.
- `start` or `clear_req` while busy: ignored, not queued.
- `comp_done` outside COMPUTE: ignored.
- Asynchronous reset mid-operation: immediate return to reset values. Bank contents are undefined for the interrupted pass.

## Timing
- RAM read latency is 1 cycle. `read_tile` in cycle T (READ) gives valid `tile_data_o` in T+1 (LATCH). The compute unit must capture it in the `comp_start` cycle.
- The compute unit holds `tile_data_i` from its `comp_done` cycle through the following WRITE cycle.
- Per tile: 3 + k cycles, where k ≥ 1 is the number of COMPUTE cycles including the `comp_done` cycle. Minimum is 4 cycles.
- Sweep: N×(3+k) + 1 cycles (the SWEEP_END cycle).
- Clear: 2N + 1 cycles from the `clear_req` cycle to the `done` pulse.
- `read_ram_a` changes only in SWEEP_END or CLR, never while `read_tile` or `write_tile` is high.

## Configuration
- `SAND_SWEEP_LIMIT_EN` defined: in SWEEP_END, when the new `sweep_count` equals `MAX_SWEEPS` and the changed-flag is set, go to IDLE with `done` pulsed and `stable`=0. `read_ram_a` toggles so the freshest bank becomes the source.
- Undefined: no limit; sweeping continues until a stable pass or `abort`.

## Test plan
- Reset, then idle: `read_ram_a`=1, `busy`=0, `tile_addr`=0, all strobes 0.
- Clear with 8×8 grid and 4×4 tiles (N=4): `reset_tile` high for 8 cycles with addresses 0,1,2,3,0,1,2,3; `read_ram_a` 1→0→1; `done` pulses 9 cycles after `clear_req`.
- `start` with `comp_done` in the first COMPUTE cycle and `tile_changed`=0 throughout: 17 cycles to `done`; `stable`=1, `sweep_count`=1, `read_ram_a`=1.
- `tile_changed`=1 on tile 2 in pass 1 only: two passes; `read_ram_a` toggles to 0 after pass 1 and stays 0 at the end; `sweep_count`=2, `stable`=1.
- `abort` during COMPUTE of tile 1: next cycle `busy`=0, `done`=1, no `write_tile` issued; a later `start` restarts at `tile_addr`=0.
- With `SAND_SWEEP_LIMIT_EN` and `MAX_SWEEPS`=3, `tile_changed` always 1: stops after 3 passes with `stable`=0, `sweep_count`=3, `read_ram_a`=0.
